// File: rtl/control_juego.sv
// ============================================================================
// control_juego
// ----------------------------------------------------------------------------
// Top-level game sequencer for HEROE.  Owns the game state register
// (OFF/WLCM/CH/GAME/WL/PA) that the collision and obstacle blocks consume as
// `presente`, advances `mundo` as obstacle steps are survived, and turns the
// collision verdict into lives, bonus score and the final result.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   btn_start     start / skip / replay / quit pulse
//   btn_pausa     pause toggle pulse
//   btn_sel       character-cycle pulse (CH screen only)
//   tick_seg      one pulse per second (screen timers)
//   tick_obs      one pulse per obstacle step
//   W_or_L        collision verdict level: 00 none, 01 lose, 10 win
//   bono_tomado   bonus level from the collision block
//   presente      current state (also the debug view of the FSM)
//   mundo         current world 0..3
//   personaje     selected character
//   vidas         remaining lives
//   puntaje       saturating bonus score
//   obs_en        obstacle scroll enable (high only in GAME)
//   gracia_act    post-hit immunity window active
//   resultado     latched outcome: 00 none, 01 lost, 10 won
//
// Interface semantics: there is no valid/ready handshake here.  Every btn_*
// and tick_* input is a single-cycle pulse that is acted on in the cycle it is
// high; W_or_L and bono_tomado are levels and only their changes (against a
// registered copy of the previous cycle) are acted on.  Every output is a flop,
// so a reaction is visible the cycle after the qualifying input.
// ============================================================================
module control_juego #(
    parameter int WLCM_SEG    = 3,
    parameter int WL_SEG      = 5,
    parameter int PASOS_MUNDO = 16,
    parameter int VIDAS_INI   = 3,
    parameter int GRACIA      = 4,
    parameter int NUM_PERS    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_pausa,
    input  logic       btn_sel,
    input  logic       tick_seg,
    input  logic       tick_obs,
    input  logic [1:0] W_or_L,
    input  logic       bono_tomado,
    output logic [2:0] presente,
    output logic [1:0] mundo,
    output logic [1:0] personaje,
    output logic [1:0] vidas,
    output logic [7:0] puntaje,
    output logic       obs_en,
    output logic       gracia_act,
    output logic [1:0] resultado
);

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        WLCM = 3'd1,
        CH   = 3'd2,
        GAME = 3'd3,
        WL   = 3'd4,
        PA   = 3'd5
    } estado_t;

    localparam logic [3:0] PASO_ULT   = 4'(PASOS_MUNDO - 1);
    localparam logic [2:0] WLCM_ULT   = 3'(WLCM_SEG - 1);
    localparam logic [2:0] WL_ULT     = 3'(WL_SEG - 1);
    localparam logic [2:0] GRACIA_INI = 3'(GRACIA);
    localparam logic [1:0] VIDAS_CARGA = 2'(VIDAS_INI);
    localparam logic [1:0] PERS_ULT   = 2'(NUM_PERS - 1);

    localparam logic [1:0] WL_NADA = 2'b00;
    localparam logic [1:0] WL_PIER = 2'b01;
    localparam logic [1:0] WL_GANA = 2'b10;

    estado_t    state_q,      state_d;
    logic [1:0] mundo_q,      mundo_d;
    logic [1:0] personaje_q,  personaje_d;
    logic [1:0] vidas_q,      vidas_d;
    logic [7:0] puntaje_q,    puntaje_d;
    logic [1:0] resultado_q,  resultado_d;
    logic [3:0] pasos_q,      pasos_d;
    logic [2:0] gracia_q,     gracia_d;
    logic [2:0] seg_q,        seg_d;
    logic [1:0] wl_prev_q,    wl_prev_d;
    logic       bono_prev_q,  bono_prev_d;
    logic       obs_en_q,     obs_en_d;
    logic       gracia_act_q, gracia_act_d;

    logic gana_sube;
    logic pierde_sube;
    logic bono_sube;

    assign gana_sube   = (W_or_L == WL_GANA) && (wl_prev_q != WL_GANA);
    assign pierde_sube = (W_or_L == WL_PIER) && (wl_prev_q != WL_PIER);
    assign bono_sube   = bono_tomado && !bono_prev_q;

    always_comb begin
        state_d     = state_q;
        mundo_d     = mundo_q;
        personaje_d = personaje_q;
        vidas_d     = vidas_q;
        puntaje_d   = puntaje_q;
        resultado_d = resultado_q;
        pasos_d     = pasos_q;
        gracia_d    = gracia_q;
        seg_d       = seg_q;
        // Edge registers sample in every state so a verdict that was already
        // present before re-entering GAME never looks like a fresh edge.
        wl_prev_d   = W_or_L;
        bono_prev_d = bono_tomado;

        case (state_q)
            OFF: begin
                if (btn_start) begin
                    state_d = WLCM;
                end
            end

            WLCM: begin
                if (btn_start) begin
                    state_d = CH;
                end else if (tick_seg) begin
                    if (seg_q == WLCM_ULT) begin
                        state_d = CH;
                    end else begin
                        seg_d = seg_q + 3'd1;
                    end
                end
            end

            CH: begin
                if (btn_sel) begin
                    personaje_d = (personaje_q == PERS_ULT) ? 2'd0 : personaje_q + 2'd1;
                end
                if (btn_start) begin
                    state_d     = GAME;
                    mundo_d     = 2'd0;
                    vidas_d     = VIDAS_CARGA;
                    puntaje_d   = 8'd0;
                    pasos_d     = 4'd0;
                    resultado_d = WL_NADA;
                    gracia_d    = 3'd0;
                end
            end

            GAME: begin
                // Priority: win > lose > pause > step advance / bonus.
                if (gana_sube) begin
                    resultado_d = WL_GANA;
                    state_d     = WL;
                end else if (pierde_sube && !gracia_act_q) begin
                    if (vidas_q == 2'd1) begin
                        vidas_d     = 2'd0;
                        resultado_d = WL_PIER;
                        state_d     = WL;
                    end else begin
                        vidas_d  = vidas_q - 2'd1;
                        pasos_d  = 4'd0;
                        gracia_d = GRACIA_INI;
                    end
                end else if (btn_pausa) begin
                    state_d = PA;
                end else begin
                    if (tick_obs) begin
                        if (pasos_q == PASO_ULT) begin
                            pasos_d = 4'd0;
                            if (mundo_q != 2'd3) begin
                                mundo_d = mundo_q + 2'd1;
                            end
                        end else begin
                            pasos_d = pasos_q + 4'd1;
                        end
                        if (gracia_q != 3'd0) begin
                            gracia_d = gracia_q - 3'd1;
                        end
                    end
                    if (bono_sube && (puntaje_q != 8'hFF)) begin
                        puntaje_d = puntaje_q + 8'd1;
                    end
                end
            end

            PA: begin
                // Everything is frozen; only the two buttons matter, and the
                // pause toggle wins over quit when both arrive together.
                if (btn_pausa) begin
                    state_d = GAME;
                end else if (btn_start) begin
                    state_d = OFF;
                end
            end

            WL: begin
                if (btn_start) begin
                    state_d = CH;
                end else if (tick_seg) begin
                    if (seg_q == WL_ULT) begin
                        state_d = OFF;
                    end else begin
                        seg_d = seg_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = OFF;
            end
        endcase

        // The screen timer restarts on every state entry.
        if (state_d != state_q) begin
            seg_d = 3'd0;
        end

        obs_en_d     = (state_d == GAME);
        gracia_act_d = (gracia_d != 3'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OFF;
            mundo_q      <= 2'd0;
            personaje_q  <= 2'd0;
            vidas_q      <= 2'd0;
            puntaje_q    <= 8'd0;
            resultado_q  <= WL_NADA;
            pasos_q      <= 4'd0;
            gracia_q     <= 3'd0;
            seg_q        <= 3'd0;
            wl_prev_q    <= 2'd0;
            bono_prev_q  <= 1'b0;
            obs_en_q     <= 1'b0;
            gracia_act_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mundo_q      <= mundo_d;
            personaje_q  <= personaje_d;
            vidas_q      <= vidas_d;
            puntaje_q    <= puntaje_d;
            resultado_q  <= resultado_d;
            pasos_q      <= pasos_d;
            gracia_q     <= gracia_d;
            seg_q        <= seg_d;
            wl_prev_q    <= wl_prev_d;
            bono_prev_q  <= bono_prev_d;
            obs_en_q     <= obs_en_d;
            gracia_act_q <= gracia_act_d;
        end
    end

    assign presente   = state_q;
    assign mundo      = mundo_q;
    assign personaje  = personaje_q;
    assign vidas      = vidas_q;
    assign puntaje    = puntaje_q;
    assign obs_en     = obs_en_q;
    assign gracia_act = gracia_act_q;
    assign resultado  = resultado_q;

endmodule
